// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Boundary-scan test sequencer. It drives TMS into the TAP controller of the
// ASIC under test and keeps a 16-state mirror of that TAP. For each command it:
//   - resynchronises the TAP after reset,
//   - shifts one instruction through Shift-IR,
//   - runs a programmable number of Shift-DR scans of BSC_Reg_size bits.
// It also paces the TDI pattern generator (load) and the TDO monitor (strobe)
// so that they stay in step with the TAP.
//
// Parameters
//   BSC_Reg_size : boundary-scan register length, in DR shift cycles (>= 2)
//   IR_size      : instruction register length, in IR shift cycles (>= 2)
//   CNT_W        : width of the pattern counter
//
// Ports
//   TCK          in   test clock; all state changes on its rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   command request, sampled only when idle in Run-Test/Idle
//   instr        in   instruction to shift (LSB first), latched with start
//   num_patterns in   number of DR scans, latched with start
//   compare_en   in   enables strobe for this command, latched with start
//   TMS          out  test mode select to the TAP
//   tdi_sel      out  1 = external TDI mux takes ir_TDI, 0 = TDI generator
//   ir_TDI       out  serial instruction bit
//   load         out  loads the next scan pattern into the TDI generator
//   strobe       out  TDO monitor compare window
//   busy         out  sequencer not idle
//   done         out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module scan_sequencer #(
  parameter int BSC_Reg_size = 14,
  parameter int IR_size      = 3,
  parameter int CNT_W        = 8
) (
  input  logic               TCK,
  input  logic               reset,
  input  logic               start,
  input  logic [IR_size-1:0] instr,
  input  logic [CNT_W-1:0]   num_patterns,
  input  logic               compare_en,
  output logic               TMS,
  output logic               tdi_sel,
  output logic               ir_TDI,
  output logic               load,
  output logic               strobe,
  output logic               busy,
  output logic               done
);

  // Shift counter must hold values up to the longer of the two scan lengths.
  localparam int SH_MAX = (BSC_Reg_size > IR_size) ? BSC_Reg_size : IR_size;
  localparam int SH_W   = (SH_MAX > 1) ? $clog2(SH_MAX) : 1;

  localparam logic [SH_W-1:0] IR_LAST  = SH_W'(IR_size - 1);
  localparam logic [SH_W-1:0] DR_LAST  = SH_W'(BSC_Reg_size - 1);
  localparam logic [2:0]      SYNC_LEN = 3'd5;

  typedef enum logic [3:0] {
    TLR,
    RTI,
    SEL_DR,
    CAP_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPD_DR,
    SEL_IR,
    CAP_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPD_IR
  } tap_state_t;

  tap_state_t           state;
  tap_state_t           state_nxt;
  logic                 go;
  logic                 ir_phase;     // IR scan of the current command not yet finished
  logic [2:0]           sync_cnt;
  logic [SH_W-1:0]      sh_cnt;
  logic [CNT_W-1:0]     pat_cnt;
  logic [IR_size-1:0]   ir_shift;
  logic                 cmp_en_q;
  logic                 done_q;
  logic                 tms;
  logic                 accept;
  logic                 finish;

  // IEEE 1149.1 TAP state transition table.
  function automatic tap_state_t tap_next(input tap_state_t s, input logic t);
    tap_state_t n;
    case (s)
      TLR:      n = t ? TLR      : RTI;
      RTI:      n = t ? SEL_DR   : RTI;
      SEL_DR:   n = t ? SEL_IR   : CAP_DR;
      CAP_DR:   n = t ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: n = t ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: n = t ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = t ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: n = t ? UPD_DR   : SHIFT_DR;
      UPD_DR:   n = t ? SEL_DR   : RTI;
      SEL_IR:   n = t ? TLR      : CAP_IR;
      CAP_IR:   n = t ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: n = t ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: n = t ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = t ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: n = t ? UPD_IR   : SHIFT_IR;
      UPD_IR:   n = t ? SEL_DR   : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

  // TMS decision, next mirror state and decoded outputs. Everything here is a
  // function of registered state only, so TMS settles once per cycle.
  always_comb begin
    tms       = 1'b1;
    accept    = 1'b0;
    finish    = 1'b0;
    state_nxt = state;
    case (state)
      TLR:      tms = (sync_cnt != SYNC_LEN);
      RTI:      tms = go;
      // Select-DR is passed twice: on the way to the IR column (first visit)
      // and on the way into each DR scan.
      SEL_DR:   tms = ir_phase;
      SEL_IR:   tms = 1'b0;
      CAP_IR:   tms = 1'b0;
      SHIFT_IR: tms = (sh_cnt == IR_LAST);
      EXIT1_IR: tms = 1'b1;
      UPD_IR:   tms = (pat_cnt != '0);
      CAP_DR:   tms = 1'b0;
      SHIFT_DR: tms = (sh_cnt == DR_LAST);
      EXIT1_DR: tms = 1'b1;
      // The count is decremented on leaving Update-DR, so another scan
      // follows only if more than one pattern remains now.
      UPD_DR:   tms = (pat_cnt > CNT_W'(1));
      default:  tms = 1'b1;
    endcase
    state_nxt = tap_next(state, tms);
    accept    = (state == RTI) && !go && start;
    finish    = go && (state != RTI) && (state_nxt == RTI);

    TMS     = tms;
    tdi_sel = (state == SHIFT_IR);
    ir_TDI  = (state == SHIFT_IR) & ir_shift[0];
    load    = (state == CAP_DR);
    strobe  = cmp_en_q & ((state == EXIT1_DR) | (state == UPD_DR));
    busy    = !((state == RTI) && !go);
    done    = done_q;
  end

  // Control registers: mirror, command flags and counters.
  always_ff @(posedge TCK or posedge reset) begin
    if (reset) begin
      state    <= TLR;
      go       <= 1'b0;
      ir_phase <= 1'b0;
      sync_cnt <= 3'd0;
      sh_cnt   <= '0;
      pat_cnt  <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= finish;

      if (accept) begin
        go       <= 1'b1;
        ir_phase <= 1'b1;
      end else if (finish) begin
        go <= 1'b0;
      end

      if (state == UPD_IR) begin
        ir_phase <= 1'b0;
      end

      // Resync counter only advances while parked in Test-Logic-Reset.
      if (state != TLR) begin
        sync_cnt <= 3'd0;
      end else if (sync_cnt != SYNC_LEN) begin
        sync_cnt <= sync_cnt + 3'd1;
      end

      if ((state == SHIFT_IR) || (state == SHIFT_DR)) begin
        sh_cnt <= sh_cnt + SH_W'(1);
      end else begin
        sh_cnt <= '0;
      end

      // Decrement gated at zero so the count can never wrap.
      if (accept) begin
        pat_cnt <= num_patterns;
      end else if ((state == UPD_DR) && (pat_cnt != '0)) begin
        pat_cnt <= pat_cnt - CNT_W'(1);
      end
    end
  end

  // Command data: instruction shifter and compare enable. Both are only
  // observed through state-gated outputs, so they need no reset.
  always_ff @(posedge TCK) begin
    if (accept) begin
      ir_shift <= instr;
      cmp_en_q <= compare_en;
    end else if (state == SHIFT_IR) begin
      ir_shift <= {1'b0, ir_shift[IR_size-1:1]};
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

  localparam int IR  = 3;
  localparam int BSC = 14;

  logic       TCK = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] instr;
  logic [7:0] num_patterns;
  logic       compare_en;
  logic       TMS, tdi_sel, ir_TDI, load, strobe, busy, done;

  logic [6:0] obs;
  logic [6:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  assign obs = {TMS, tdi_sel, ir_TDI, load, strobe, busy, done};

  scan_sequencer #(
    .BSC_Reg_size(BSC),
    .IR_size     (IR),
    .CNT_W       (8)
  ) dut (
    .TCK         (TCK),
    .reset       (reset),
    .start       (start),
    .instr       (instr),
    .num_patterns(num_patterns),
    .compare_en  (compare_en),
    .TMS         (TMS),
    .tdi_sel     (tdi_sel),
    .ir_TDI      (ir_TDI),
    .load        (load),
    .strobe      (strobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 TCK = ~TCK;

  // Output vector order: TMS, tdi_sel, ir_TDI, load, strobe, busy, done
  function automatic logic [6:0] v(input bit tms, tsel, tdi, ld, stb, bsy, dn);
    return {tms, tsel, tdi, ld, stb, bsy, dn};
  endfunction

  // Expected per-cycle outputs of one command, starting with the cycle after
  // the accept edge and ending with the done cycle.
  function automatic void push_cmd(input logic [2:0] ins, input int n, input bit cmp);
    exp_q.push_back(v(1, 0, 0, 0, 0, 1, 0));             // RTI, go set
    exp_q.push_back(v(1, 0, 0, 0, 0, 1, 0));             // Select-DR
    exp_q.push_back(v(0, 0, 0, 0, 0, 1, 0));             // Select-IR
    exp_q.push_back(v(0, 0, 0, 0, 0, 1, 0));             // Capture-IR
    for (int i = 0; i < IR; i++)
      exp_q.push_back(v(i == IR - 1, 1, ins[i], 0, 0, 1, 0));
    exp_q.push_back(v(1, 0, 0, 0, 0, 1, 0));             // Exit1-IR
    exp_q.push_back(v(n != 0, 0, 0, 0, 0, 1, 0));        // Update-IR
    for (int p = 0; p < n; p++) begin
      exp_q.push_back(v(0, 0, 0, 0, 0, 1, 0));           // Select-DR
      exp_q.push_back(v(0, 0, 0, 1, 0, 1, 0));           // Capture-DR
      for (int j = 0; j < BSC; j++)
        exp_q.push_back(v(j == BSC - 1, 0, 0, 0, 0, 1, 0));
      exp_q.push_back(v(1, 0, 0, 0, cmp, 1, 0));         // Exit1-DR
      exp_q.push_back(v(p != n - 1, 0, 0, 0, cmp, 1, 0)); // Update-DR
    end
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 1));             // RTI, done
  endfunction

  task automatic test_reset(input string name);
    logic [6:0] e;
    int idx;
    reset = 1'b1;
    start = 1'b0;
    #1;
    n_checks++;
    if (obs !== v(1, 0, 0, 0, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL %s_async got=%b expected=%b", name, obs, v(1, 0, 0, 0, 0, 1, 0));
    end
    @(posedge TCK);
    @(posedge TCK);
    @(negedge TCK);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(v(1, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 1, 0));   // after r+5: TMS drops, still TLR
    exp_q.push_back(v(0, 0, 0, 0, 0, 0, 0));   // after r+6: RTI, idle
    idx = 0;
    while (exp_q.size() > 0) begin
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s_resync idx=%0d got=%b expected=%b", name, idx, obs, e);
      end
      @(negedge TCK);
      idx++;
    end
  endtask

  task automatic test_command(input string name, input logic [2:0] ins, input int n,
                              input bit cmp, input int pulse_idx);
    logic [6:0] e;
    int idx, done_idx, done_cnt, load_cnt, exp_done;
    push_cmd(ins, n, cmp);
    instr        = ins;
    num_patterns = 8'(n);
    compare_en   = cmp;
    start        = 1'b1;
    @(posedge TCK);
    #1;
    start        = 1'b0;
    instr        = ~ins;      // latched values must be used from here on
    num_patterns = 8'd0;
    compare_en   = ~cmp;
    idx = 0; done_idx = -1; done_cnt = 0; load_cnt = 0;
    while (exp_q.size() > 0) begin
      @(negedge TCK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s idx=%0d got=%b expected=%b", name, idx, obs, e);
      end
      if (done === 1'b1) begin done_idx = idx; done_cnt++; end
      if (load === 1'b1) load_cnt++;
      if (idx == pulse_idx) start = 1'b1;
      @(posedge TCK);
      #1;
      start = 1'b0;
      idx++;
    end
    exp_done = (n == 0) ? 9 : 10 + IR + BSC + (n - 1) * (4 + BSC);
    n_checks++;
    if (done_idx !== exp_done || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL %s_done_time got=k+%0d (pulses %0d) expected=k+%0d (pulses 1)",
               name, done_idx, done_cnt, exp_done);
    end
    n_checks++;
    if (load_cnt !== n) begin
      n_fail++;
      $display("FAIL %s_load_count got=%0d expected=%0d", name, load_cnt, n);
    end
  endtask

  // start held high: second command accepted on the first idle edge after done.
  task automatic test_back_to_back();
    logic [6:0] e;
    int idx, len_a;
    int dones[$];
    push_cmd(3'b011, 1, 1'b1);
    len_a = exp_q.size();
    push_cmd(3'b110, 0, 1'b0);
    instr        = 3'b011;
    num_patterns = 8'd1;
    compare_en   = 1'b1;
    start        = 1'b1;
    @(posedge TCK);
    #1;
    instr        = 3'b110;
    num_patterns = 8'd0;
    compare_en   = 1'b0;
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge TCK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back idx=%0d got=%b expected=%b", idx, obs, e);
      end
      if (done === 1'b1) dones.push_back(idx);
      @(posedge TCK);
      #1;
      idx++;
      if (idx >= len_a) start = 1'b0;
    end
    n_checks++;
    if (dones.size() != 2) begin
      n_fail++;
      $display("FAIL back_to_back_done_count got=%0d expected=2", dones.size());
    end else if (dones[0] != 10 + IR + BSC || dones[1] != 10 + IR + BSC + 1 + 9) begin
      n_fail++;
      $display("FAIL back_to_back_done_time got=k+%0d,k+%0d expected=k+%0d,k+%0d",
               dones[0], dones[1], 10 + IR + BSC, 10 + IR + BSC + 10);
    end
  endtask

  task automatic test_reset_abort();
    logic [6:0] e;
    push_cmd(3'b101, 1, 1'b1);
    instr        = 3'b101;
    num_patterns = 8'd1;
    compare_en   = 1'b1;
    start        = 1'b1;
    @(posedge TCK);
    #1;
    start = 1'b0;
    for (int idx = 0; idx <= 14; idx++) begin
      @(negedge TCK);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL abort_pre idx=%0d got=%b expected=%b", idx, obs, e);
      end
      if (idx < 14) begin
        @(posedge TCK);
        #1;
      end
    end
    exp_q.delete();
    test_reset("abort");
    test_command("after_abort", 3'b100, 1, 1'b1, -1);
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    instr        = 3'b000;
    num_patterns = 8'd0;
    compare_en   = 1'b0;
    #3;
    test_reset("reset");
    test_command("basic", 3'b101, 1, 1'b1, -1);
    test_command("multi_ignore_start", 3'b010, 3, 1'b1, 4);
    test_command("zero_patterns", 3'b111, 0, 1'b1, -1);
    test_command("compare_off", 3'b001, 2, 1'b0, 4);
    test_command("max_patterns", 3'b110, 255, 1'b1, -1);
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
